fp_add_pipe: RTL and testbench

- Parametrised, 3-stage pipelined IEEE-754 floating-point adder/subtractor; successor to the combinational binary16 adder.
- Generic exponent/fraction widths; add or subtract mode per operation.
- Full subnormal support, round-to-nearest-even, NaN/Inf handling, exception flags.
- Sits between the accelerator operand fetch and result writeback. Valid/ready on both sides, one result per cycle sustained.

---
 rtl/fp_add_pipe.sv | 182 ++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fp_add_pipe.sv
// Three-stage IEEE-754 adder/subtractor: align, add, normalise/round/pack.
// Latency 3 cycles; valid/ready stall chain lets each stage load when the next one frees.
module fp_add_pipe #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10,
  localparam int W     = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [3:0]   out_flags
);
  localparam int SW = FRAC_W + 1;   // significand with hidden bit
  localparam int AW = FRAC_W + 3;   // significand + guard + round
  localparam int XW = FRAC_W + 4;   // + sticky
  localparam logic [EXP_W-1:0] EMAX   = '1;
  localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(AW);
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(FRAC_W-1){1'b0}}};

  logic v1, v2, v3, ld1, ld2, ld3;
  assign ld3       = !v3 || out_ready;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;

  // Stage 1: unpack, classify, order by magnitude, align the smaller operand
  logic                 a_sign, b_sign, a_hid, b_hid, swap;
  logic [EXP_W-1:0]     a_exp, b_exp, a_eexp, b_eexp, big_eexp, sml_eexp, diff, sh;
  logic [FRAC_W-1:0]    a_frac, b_frac;
  logic [SW-1:0]        big_sig, sml_sig;
  logic [2*AW-1:0]      wide;
  logic                 a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
  logic [W-1:0]         spec_res;
  logic [3:0]           spec_flags;

  always_comb begin
    a_sign   = in_a[W-1];
    b_sign   = in_b[W-1] ^ in_sub;
    a_exp    = in_a[W-2:FRAC_W];
    b_exp    = in_b[W-2:FRAC_W];
    a_frac   = in_a[FRAC_W-1:0];
    b_frac   = in_b[FRAC_W-1:0];
    a_hid    = |a_exp;
    b_hid    = |b_exp;
    a_eexp   = a_hid ? a_exp : EXP_W'(1);
    b_eexp   = b_hid ? b_exp : EXP_W'(1);
    swap     = in_b[W-2:0] > in_a[W-2:0];
    big_sig  = swap ? {b_hid, b_frac} : {a_hid, a_frac};
    sml_sig  = swap ? {a_hid, a_frac} : {b_hid, b_frac};
    big_eexp = swap ? b_eexp : a_eexp;
    sml_eexp = swap ? a_eexp : b_eexp;
    diff     = big_eexp - sml_eexp;
    sh       = (diff >= SH_MAX) ? SH_MAX : diff;
    wide     = {sml_sig, 2'b00, {AW{1'b0}}} >> sh;

    a_nan  = (&a_exp) && (|a_frac);
    b_nan  = (&b_exp) && (|b_frac);
    a_snan = a_nan && !a_frac[FRAC_W-1];
    b_snan = b_nan && !b_frac[FRAC_W-1];
    a_inf  = (&a_exp) && !(|a_frac);
    b_inf  = (&b_exp) && !(|b_frac);
    if (a_nan || b_nan) begin
      spec_res   = QNAN;
      spec_flags = {a_snan || b_snan, 3'b000};
    end else if (a_inf && b_inf && (a_sign != b_sign)) begin
      spec_res   = QNAN;
      spec_flags = 4'b1000;
    end else if (a_inf) begin
      spec_res   = {a_sign, EMAX, {FRAC_W{1'b0}}};
      spec_flags = 4'b0000;
    end else begin
      spec_res   = {b_sign, EMAX, {FRAC_W{1'b0}}};
      spec_flags = 4'b0000;
    end
  end

  logic [XW-1:0]    s1_big, s1_sml;
  logic [EXP_W-1:0] s1_exp, s2_exp;
  logic             s1_sign, s1_sub, s1_spec, s2_sign, s2_sub, s2_spec;
  logic [W-1:0]     s1_spec_res, s2_spec_res;
  logic [3:0]       s1_spec_flags, s2_spec_flags;
  logic [XW:0]      s2_sum;

  // Stage 3: normalise, round to nearest even, pack
  int               lz, lim, shl;
  logic [XW-1:0]    n;
  logic [EXP_W:0]   e, ef;
  logic [SW:0]      mant;
  logic             g, r, s, inc, nx, rsign;
  logic [FRAC_W-1:0] frac;
  logic [W-1:0]     res3;
  logic [3:0]       flags3;

  always_comb begin
    lz = XW;
    for (int i = 0; i < XW; i++)
      if (s2_sum[i]) lz = XW - 1 - i;
    lim = int'(s2_exp) - 1;
    shl = (lz < lim) ? lz : lim;
    if (s2_sum[XW]) begin
      n = {s2_sum[XW:2], s2_sum[1] | s2_sum[0]};
      e = {1'b0, s2_exp} + (EXP_W+1)'(1);
    end else begin
      n = s2_sum[XW-1:0] << shl;
      e = {1'b0, s2_exp} - (EXP_W+1)'(shl);
    end
    g    = n[2];
    r    = n[1];
    s    = n[0];
    inc  = g && (r || s || n[3]);
    mant = {1'b0, n[XW-1:3]} + {{SW{1'b0}}, inc};
    // A carry into the hidden bit turns a subnormal into the smallest normal for free
    if (mant[SW]) begin
      ef   = e + (EXP_W+1)'(1);
      frac = mant[SW-1:1];
    end else begin
      ef   = mant[SW-1] ? e : '0;
      frac = mant[FRAC_W-1:0];
    end
    nx    = g || r || s;
    rsign = (s2_sub && !(|s2_sum)) ? 1'b0 : s2_sign;
    if (s2_spec) begin
      res3   = s2_spec_res;
      flags3 = s2_spec_flags;
    end else if (ef >= {1'b0, EMAX}) begin
      res3   = {s2_sign, EMAX, {FRAC_W{1'b0}}};
      flags3 = 4'b0101;
    end else begin
      res3   = {rsign, ef[EXP_W-1:0], frac};
      flags3 = {2'b00, (ef == '0) && nx, nx};
    end
  end

  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      s1_big        <= {big_sig, 3'b000};
      s1_sml        <= {wide[2*AW-1:AW], |wide[AW-1:0]};
      s1_exp        <= big_eexp;
      s1_sign       <= swap ? b_sign : a_sign;
      s1_sub        <= a_sign ^ b_sign;
      s1_spec       <= a_nan || b_nan || a_inf || b_inf;
      s1_spec_res   <= spec_res;
      s1_spec_flags <= spec_flags;
    end
    if (ld2 && v1) begin
      s2_sum        <= s1_sub ? ({1'b0, s1_big} - {1'b0, s1_sml})
                              : ({1'b0, s1_big} + {1'b0, s1_sml});
      s2_exp        <= s1_exp;
      s2_sign       <= s1_sign;
      s2_sub        <= s1_sub;
      s2_spec       <= s1_spec;
      s2_spec_res   <= s1_spec_res;
      s2_spec_flags <= s1_spec_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
      if (ld3 && v2) begin
        out_result <= res3;
        out_flags  <= flags3;
      end
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: binary16 vectors, streaming with backpressure,
// mid-flight reset, and a binary32 instance.
module tb_fp_add_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [15:0] in_a, in_b, out_result;
  logic [3:0]  out_flags;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] in_a32, in_b32, out_result32;
  logic [3:0]  out_flags32;

  always #5 clk = ~clk;

  fp_add_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
  );

  fp_add_pipe #(.EXP_W(8), .FRAC_W(23)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_a(in_a32), .in_b(in_b32), .in_sub(1'b0), .out_valid(out_valid32),
    .out_ready(out_ready32), .out_result(out_result32), .out_flags(out_flags32)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] r;
    logic [3:0]  f;
  } vec_t;
  vec_t vt[11];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Starts and ends #1 after a rising edge with out_ready held high
  task automatic run16(input int i);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = vt[i].a;
    in_b      = vt[i].b;
    in_sub    = vt[i].sub;
    #1;
    chk($sformatf("in_ready_%0d", i), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("latency_%0d", i), lat, 3);
    chk($sformatf("result_%0d", i), out_result, vt[i].r);
    chk($sformatf("flags_%0d", i), out_flags, vt[i].f);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc_cnt, dlv_cnt, occ, cyc, seen;
    logic do_acc, do_dlv, stalled;
    logic [15:0] held_r;
    logic [3:0]  held_f, pat;

    vt[0]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'h0};
    vt[1]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'h5};
    vt[2]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'h0};
    vt[3]  = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'h0};
    vt[4]  = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'h1};
    vt[5]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'h1};
    vt[6]  = '{16'h3C00, 16'h1001, 1'b0, 16'h3C01, 4'h1};
    vt[7]  = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 4'h0};
    vt[8]  = '{16'h0400, 16'h0001, 1'b1, 16'h03FF, 4'h0};
    vt[9]  = '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'h8};
    vt[10] = '{16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 4'h8};

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    in_valid32 = 1'b0; in_a32 = '0; in_b32 = '0; out_ready32 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flags", out_flags, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 11; i++) run16(i);

    // Streaming: out_ready follows 1,0,0,1 per cycle
    pat = 4'b1001;
    acc_cnt = 0; dlv_cnt = 0; occ = 0; cyc = 0; stalled = 1'b0;
    held_r = '0; held_f = '0;
    while (dlv_cnt < 8 && cyc < 200) begin
      out_ready = pat[cyc % 4];
      in_valid  = (acc_cnt < 8);
      if (acc_cnt < 8) begin
        in_a   = vt[acc_cnt].a;
        in_b   = vt[acc_cnt].b;
        in_sub = vt[acc_cnt].sub;
      end
      #1;
      chk("stream_in_ready", in_ready, !(occ == 3 && !out_ready));
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_result", out_result, held_r);
        chk("stall_flags", out_flags, held_f);
      end
      do_acc = in_valid && in_ready;
      do_dlv = out_valid && out_ready;
      if (do_dlv) begin
        chk($sformatf("stream_result_%0d", dlv_cnt), out_result, vt[dlv_cnt].r);
        chk($sformatf("stream_flags_%0d", dlv_cnt), out_flags, vt[dlv_cnt].f);
      end
      stalled = out_valid && !out_ready;
      held_r  = out_result;
      held_f  = out_flags;
      @(posedge clk); #1;
      if (do_acc) begin acc_cnt++; occ++; end
      if (do_dlv) begin dlv_cnt++; occ--; end
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_delivered", dlv_cnt, 8);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("stream_no_dup", out_valid, 0);

    // Reset with three operations in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = vt[i + 4].a; in_b = vt[i + 4].b; in_sub = vt[i + 4].sub;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("full_out_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_result", out_result, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("midrst_in_ready", in_ready, 1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_ghost", seen, 0);
    run16(0);

    // binary32 instance
    in_valid32 = 1'b1;
    in_a32 = 32'h3F80_0000;
    in_b32 = 32'h3F80_0000;
    #1;
    chk("w32_in_ready", in_ready32, 1);
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    seen = 1;
    while (!out_valid32 && seen < 10) begin
      @(posedge clk); #1;
      seen++;
    end
    chk("w32_latency", seen, 3);
    chk("w32_result", out_result32, 32'h4000_0000);
    chk("w32_flags", out_flags32, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
